// File: rtl/return_stack.sv
// LIFO return-address stack with occupancy tracking, tail-call replace,
// selectable wrap/block overflow policy and sticky error flags.
module return_stack #(
  parameter int WIDTH        = 11,
  parameter int DEPTH        = 16,
  parameter int WRAP_ON_FULL = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           stack_in,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           stack_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_en_d;
  logic [PW-1:0]    wr_addr_d;
  logic [PW-1:0]    ptr_inc, ptr_dec;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign stack_out = empty ? '0 : mem_q[ptr_q];

  // DEPTH is a power of two, so pointer arithmetic wraps for free
  assign ptr_inc = ptr_q + PW'(1);
  assign ptr_dec = ptr_q - PW'(1);

  always_comb begin
    ptr_d       = ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    wr_en_d     = 1'b0;
    wr_addr_d   = ptr_inc;
    unique case ({push, pop})
      2'b10: begin
        if (!full) begin
          wr_en_d = 1'b1;
          ptr_d   = ptr_inc;
          count_d = count_q + CW'(1);
        end else begin
          overflow_d = 1'b1;
          if (WRAP_ON_FULL != 0) begin
            wr_en_d = 1'b1;
            ptr_d   = ptr_inc;
          end
        end
      end
      2'b01: begin
        if (!empty) begin
          ptr_d   = ptr_dec;
          count_d = count_q - CW'(1);
        end else begin
          underflow_d = 1'b1;
        end
      end
      2'b11: begin
        wr_en_d = 1'b1;
        if (empty) begin
          ptr_d   = ptr_inc;
          count_d = CW'(1);
        end else begin
          wr_addr_d = ptr_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= PW'(DEPTH-1);
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset; writes are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (wr_en_d && reset_n) begin
      mem_q[wr_addr_d] <= stack_in;
    end
  end

endmodule

// File: tb/tb_return_stack.sv
// Checks three return_stack configurations against an ordered-list model
// with directed scenarios followed by randomized push/pop traffic.
module tb_return_stack;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        push, pop, clr_err;
  logic [10:0] stack_in;

  logic [10:0] so   [3];
  logic        emp  [3];
  logic        ful  [3];
  logic        ovf  [3];
  logic        unf  [3];
  logic [4:0]  cnt  [3];
  logic [4:0]  cnt0;
  logic [2:0]  cnt1, cnt2;

  int checks   = 0;
  int failures = 0;

  int mdl   [3][16];
  int msize [3];
  bit mov   [3];
  bit mun   [3];
  int mdep  [3] = '{16, 4, 4};
  bit mwrap [3] = '{1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  return_stack #(.WIDTH(11), .DEPTH(16), .WRAP_ON_FULL(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .stack_in(stack_in),
    .clr_err(clr_err), .stack_out(so[0]), .empty(emp[0]), .full(ful[0]),
    .count(cnt0), .overflow(ovf[0]), .underflow(unf[0]));

  return_stack #(.WIDTH(11), .DEPTH(4), .WRAP_ON_FULL(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .stack_in(stack_in),
    .clr_err(clr_err), .stack_out(so[1]), .empty(emp[1]), .full(ful[1]),
    .count(cnt1), .overflow(ovf[1]), .underflow(unf[1]));

  return_stack #(.WIDTH(11), .DEPTH(4), .WRAP_ON_FULL(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .stack_in(stack_in),
    .clr_err(clr_err), .stack_out(so[2]), .empty(emp[2]), .full(ful[2]),
    .count(cnt2), .overflow(ovf[2]), .underflow(unf[2]));

  assign cnt[0] = cnt0;
  assign cnt[1] = {2'b00, cnt1};
  assign cnt[2] = {2'b00, cnt2};

  task automatic cmp(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    assert (act === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      msize[k] = 0;
      mov[k]   = 1'b0;
      mun[k]   = 1'b0;
    end
  endtask

  // Stack kept as an ordered list: index 0 is the oldest entry
  task automatic modelStep(input bit p, input bit po, input int d, input bit c);
    for (int k = 0; k < 3; k++) begin
      if (c) begin
        mov[k] = 1'b0;
        mun[k] = 1'b0;
      end
      if (p && po) begin
        if (msize[k] == 0) begin
          mdl[k][0] = d;
          msize[k]  = 1;
        end else begin
          mdl[k][msize[k]-1] = d;
        end
      end else if (p) begin
        if (msize[k] < mdep[k]) begin
          mdl[k][msize[k]] = d;
          msize[k]++;
        end else begin
          mov[k] = 1'b1;
          if (mwrap[k]) begin
            for (int i = 0; i < mdep[k]-1; i++) mdl[k][i] = mdl[k][i+1];
            mdl[k][mdep[k]-1] = d;
          end
        end
      end else if (po) begin
        if (msize[k] > 0) msize[k]--;
        else mun[k] = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 3; k++) begin
      int expTop;
      expTop = (msize[k] == 0) ? 0 : mdl[k][msize[k]-1];
      cmp($sformatf("dut%0d.stack_out", k), 16'(so[k]), 16'(expTop));
      cmp($sformatf("dut%0d.count", k), 16'(cnt[k]), 16'(msize[k]));
      cmp($sformatf("dut%0d.empty", k), 16'(emp[k]), 16'(msize[k] == 0));
      cmp($sformatf("dut%0d.full", k), 16'(ful[k]), 16'(msize[k] == mdep[k]));
      cmp($sformatf("dut%0d.overflow", k), 16'(ovf[k]), 16'(mov[k]));
      cmp($sformatf("dut%0d.underflow", k), 16'(unf[k]), 16'(mun[k]));
    end
  endtask

  task automatic applyStimulus(input bit p, input bit po, input logic [10:0] d, input bit c);
    @(negedge clk);
    push     = p;
    pop      = po;
    stack_in = d;
    clr_err  = c;
    @(posedge clk);
    modelStep(p, po, int'(d), c);
    #1;
    checkOutput();
  endtask

  initial begin
    reset_n  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    clr_err  = 1'b0;
    stack_in = '0;
    modelReset();

    // Reset toggled away from clock edges
    #12;
    checkOutput();
    cmp("reset.stack_out", 16'(so[0]), 16'h0);
    cmp("reset.empty", 16'(emp[0]), 16'h1);
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1 checkOutput();

    // Basic push/pop ordering
    applyStimulus(1, 0, 11'h101, 0);
    cmp("t2.so1", 16'(so[0]), 16'h101);
    cmp("t2.cnt1", 16'(cnt[0]), 16'd1);
    applyStimulus(1, 0, 11'h202, 0);
    cmp("t2.so2", 16'(so[0]), 16'h202);
    applyStimulus(1, 0, 11'h303, 0);
    cmp("t2.so3", 16'(so[0]), 16'h303);
    cmp("t2.cnt3", 16'(cnt[0]), 16'd3);
    applyStimulus(0, 1, 11'h0, 0);
    cmp("t2.pop1", 16'(so[0]), 16'h202);
    applyStimulus(0, 1, 11'h0, 0);
    cmp("t2.pop2", 16'(so[0]), 16'h101);
    applyStimulus(0, 1, 11'h0, 0);
    cmp("t2.pop3", 16'(so[0]), 16'h0);
    cmp("t2.empty", 16'(emp[0]), 16'h1);

    // Underflow and sticky clear with set-wins
    applyStimulus(0, 1, 11'h0, 0);
    cmp("t3.unf", 16'(unf[0]), 16'h1);
    cmp("t3.cnt", 16'(cnt[0]), 16'd0);
    applyStimulus(0, 1, 11'h0, 1);
    cmp("t3.setwins", 16'(unf[0]), 16'h1);
    applyStimulus(0, 0, 11'h0, 1);
    cmp("t3.cleared", 16'(unf[0]), 16'h0);

    // Replace-top and replace-on-empty
    applyStimulus(1, 0, 11'h0AA, 0);
    applyStimulus(1, 0, 11'h0BB, 0);
    applyStimulus(1, 1, 11'h7FF, 0);
    cmp("t4.replace", 16'(so[0]), 16'h7FF);
    cmp("t4.cnt", 16'(cnt[0]), 16'd2);
    applyStimulus(0, 1, 11'h0, 0);
    cmp("t4.pop", 16'(so[0]), 16'h0AA);
    applyStimulus(0, 1, 11'h0, 0);
    applyStimulus(1, 1, 11'h055, 0);
    cmp("t4.emptyrep.cnt", 16'(cnt[0]), 16'd1);
    cmp("t4.emptyrep.so", 16'(so[0]), 16'h055);
    cmp("t4.emptyrep.unf", 16'(unf[0]), 16'h0);
    applyStimulus(0, 1, 11'h0, 1);

    // Full behaviour: dut1 blocks, dut2 wraps
    for (int v = 1; v <= 4; v++) applyStimulus(1, 0, 11'(v), 0);
    cmp("t5.full", 16'(ful[1]), 16'h1);
    applyStimulus(1, 0, 11'd5, 0);
    cmp("t5.ovf", 16'(ovf[1]), 16'h1);
    cmp("t5.so", 16'(so[1]), 16'd4);
    cmp("t5.cnt", 16'(cnt[1]), 16'd4);
    applyStimulus(1, 0, 11'd6, 0);
    cmp("t6.so", 16'(so[2]), 16'd6);
    cmp("t6.cnt", 16'(cnt[2]), 16'd4);
    cmp("t6.ovf", 16'(ovf[2]), 16'h1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 11'h0, 0);
      cmp($sformatf("t5.pop%0d", i), 16'(so[1]), 16'(3 - i));
      cmp($sformatf("t6.pop%0d", i), 16'(so[2]), 16'((i == 3) ? 0 : 5 - i));
    end
    cmp("t6.empty", 16'(emp[2]), 16'h1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                    11'($urandom), $urandom_range(0, 99) < 5);
    end

    // Asynchronous reset mid-operation, with a push held across a reset edge
    @(negedge clk);
    push     = 1'b1;
    stack_in = 11'h3C3;
    #2 reset_n = 1'b0;
    modelReset();
    #1 checkOutput();
    @(posedge clk);
    #1 checkOutput();
    @(negedge clk);
    push = 1'b0;
    #2 reset_n = 1'b1;
    applyStimulus(1, 0, 11'h1E1, 0);
    cmp("postreset.so", 16'(so[0]), 16'h1E1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/return_stack.md
# return_stack

Parametrised hardware stack for the CPU's call/return path. It stores WIDTH-bit entries, normally return addresses, in a DEPTH-entry LIFO. On top of plain push and pop it provides:
- occupancy count and full/empty flags;
- a simultaneous push+pop that replaces the top entry (tail-call);
- a configurable overflow policy, either wrap or block;
- sticky overflow and underflow error flags.

It sits beside the program counter logic and replaces the fixed 11-bit, 16-entry stack.

## Interface
Parameters:
- WIDTH, 11: entry width in bits.
- DEPTH, 16: number of entries. Must be a power of two, at least 2.
- WRAP_ON_FULL, 0: overflow policy. 1 = a push when full overwrites the oldest entry (circular). 0 = a push when full is dropped.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- push  input  1  push stack_in this cycle.
- pop  input  1  pop the top entry this cycle.
- stack_in  input  WIDTH  data to push or replace.
- clr_err  input  1  synchronous clear of both sticky error flags.
- stack_out  output  WIDTH  current top entry; forced to 0 while empty.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  $clog2(DEPTH+1)  number of valid entries.
- overflow  output  1  sticky; a push was issued while full.
- underflow  output  1  sticky; a pop was issued while empty.

## Operation
- State:
  - top pointer ptr, $clog2(DEPTH) bits, arithmetic modulo DEPTH;
  - count register;
  - two sticky flags;
  - DEPTH x WIDTH storage array.
- The storage array is not reset.
- Reset (reset_n low, asynchronous assert, synchronous-style release):
  - ptr = DEPTH-1, count = 0, overflow = 0, underflow = 0;
  - hence stack_out = 0, empty = 1, full = 0.
- stack_out = empty ? 0 : mem[ptr]. It is combinational from registers only; no combinational path from push, pop or stack_in.
- Per-cycle action, decided on push and pop at the rising edge:
  - Neither asserted: hold.
  - Push only, not full: mem[ptr+1] = stack_in; ptr += 1; count += 1.
  - Push only, full, WRAP_ON_FULL = 1: mem[ptr+1] = stack_in; ptr += 1 (wraps); count stays DEPTH; overflow = 1. The oldest entry is lost.
  - Push only, full, WRAP_ON_FULL = 0: no write, ptr and count unchanged; overflow = 1.
  - Pop only, not empty: ptr -= 1; count -= 1. Entry contents are left in place.
  - Pop only, empty: no change to ptr or count; underflow = 1.
  - Push and pop, not empty: replace. mem[ptr] = stack_in; ptr and count unchanged. No error flag is set, including when full.
  - Push and pop, empty: behaves as a push-only on an empty stack. count becomes 1; no underflow.
- Sticky flags:
  - Set only by the events listed above.
  - Cleared by clr_err = 1 at a clock edge.
  - If clr_err and a setting event occur in the same cycle, the flag ends at 1 (set wins).
- Wrap-around: ptr increments from DEPTH-1 to 0 and decrements from 0 to DEPTH-1. count never exceeds DEPTH and never goes below 0.

## Timing
- An operation sampled at edge N is visible on stack_out, count, empty, full and the flags immediately after edge N. Push-to-read latency is one edge.
- Back-to-back push/pop on every cycle is supported, with no bubbles.
- reset_n asserted mid-operation clears all state immediately, without waiting for clk. Any push or pop on the edge where reset_n is low is ignored.
- After reset_n deasserts, the first operation is accepted on the next rising edge.

## Test plan
Default parameters unless stated.
1. Reset then idle: stack_out = 0, empty = 1, count = 0, overflow = underflow = 0, with reset_n toggled asynchronously between edges.
2. Push 0x101, 0x202, 0x303, then pop three times:
   - stack_out after the pushes: 0x101, 0x202, 0x303;
   - stack_out after the pops: 0x202, 0x101, 0 with empty = 1;
   - count sequence: 1, 2, 3, 2, 1, 0.
3. Pop when empty: count stays 0 and underflow = 1. Then clr_err together with another empty pop: underflow stays 1. Then clr_err alone: underflow = 0.
4. Push and pop together:
   - After pushes 0x0AA, 0x0BB, push+pop with 0x7FF gives stack_out = 0x7FF, count = 2. A following pop gives stack_out = 0x0AA.
   - Push+pop with 0x055 when empty gives count = 1, stack_out = 0x055, underflow = 0.
5. DEPTH = 4, WRAP_ON_FULL = 0:
   - Push 1, 2, 3, 4 gives full = 1.
   - Push 5 gives overflow = 1, stack_out = 4, count = 4.
   - Four pops return 3, 2, 1, then empty.
6. DEPTH = 4, WRAP_ON_FULL = 1:
   - Push 1 through 6 gives count = 4, overflow = 1, stack_out = 6.
   - Pops give stack_out 5, 4, 3, then 0 with empty = 1. Entries 1 and 2 are lost; the pointer wrap is verified.
